rr_arb_mux: RTL and testbench

- N-source round-robin arbitrated one-hot mux with valid/ready handshakes on every input and a single registered output stage.
- Used in the L1D where several request sources (load pipes, refill, writeback, snoop) share one downstream port.
- Arbitrates a one-hot grant, AND-OR selects the winner's payload, and registers it with 1-cycle latency at full throughput.

---
 rtl/rr_arb_mux_pkg.sv | 39 +++
 rtl/rr_arb_mux_arbiter.sv | 53 +++++
 rtl/rr_arb_mux.sv | 89 ++++++++
 tb/tb_rr_arb_mux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for rr_arb_mux: one-hot encoder and round-robin priority mask, both capped at 16 sources.
package rr_arb_mux_pkg;

  localparam int RR_ARB_MUX_MAX_SOURCES = 16;

  // Binary index of the set bit; only the low 'width' bits are considered.
  function automatic logic [3:0] onehot_to_idx(
    input logic [RR_ARB_MUX_MAX_SOURCES-1:0] oh,
    input int                                width
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < RR_ARB_MUX_MAX_SOURCES; i++) begin
      if ((i < width) && oh[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

  // Thermometer of bits strictly above the one-hot pointer, within 'width'.
  function automatic logic [RR_ARB_MUX_MAX_SOURCES-1:0] rr_mask(
    input logic [RR_ARB_MUX_MAX_SOURCES-1:0] ptr_oh,
    input int                                width
  );
    logic [RR_ARB_MUX_MAX_SOURCES-1:0] mask;
    logic                              seen;
    mask = '0;
    seen = 1'b0;
    for (int i = 0; i < RR_ARB_MUX_MAX_SOURCES; i++) begin
      if (i < width) begin
        mask[i] = seen;
        seen    = seen | ptr_oh[i];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting just above last_grant, wrapping.
// Zero latency; the pointer moves only when advance_i reports an accepted transfer.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int SOURCE_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SOURCE_COUNT-1:0] req_i,
  input  logic                    advance_i,
  output logic [SOURCE_COUNT-1:0] grant_oh_o
);

  localparam logic [SOURCE_COUNT-1:0] LP_PTR_RST = {1'b1, {(SOURCE_COUNT-1){1'b0}}};

  logic [SOURCE_COUNT-1:0] r_last_grant;
  logic [SOURCE_COUNT-1:0] w_mask;
  logic [SOURCE_COUNT-1:0] w_req_masked;
  logic [SOURCE_COUNT-1:0] w_pick_masked;
  logic [SOURCE_COUNT-1:0] w_pick_plain;

  function automatic logic [SOURCE_COUNT-1:0] f_lowest(input logic [SOURCE_COUNT-1:0] v);
    logic [SOURCE_COUNT-1:0] r;
    logic                    found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign w_mask        = SOURCE_COUNT'(rr_mask(RR_ARB_MUX_MAX_SOURCES'(r_last_grant), SOURCE_COUNT));
  assign w_req_masked  = req_i & w_mask;
  assign w_pick_masked = f_lowest(w_req_masked);
  assign w_pick_plain  = f_lowest(req_i);

  // Nothing above the pointer requesting means the search wraps to bit 0.
  assign grant_oh_o = (|w_req_masked) ? w_pick_masked : w_pick_plain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= LP_PTR_RST;
    end else if (advance_i) begin
      r_last_grant <= grant_oh_o;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-source round-robin one-hot mux with one registered output stage: 1-cycle latency, full throughput.
// Optional RR_ARB_MUX_PRIO_EN adds prio_i; high-priority requesters are arbitrated first.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int SOURCE_COUNT = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int IDX_WIDTH    = $clog2(SOURCE_COUNT)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [SOURCE_COUNT-1:0]                valid_i,
  input  logic [SOURCE_COUNT-1:0][DATA_WIDTH-1:0] data_i,
`ifdef RR_ARB_MUX_PRIO_EN
  input  logic [SOURCE_COUNT-1:0]                prio_i,
`endif
  output logic [SOURCE_COUNT-1:0]                ready_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic [DATA_WIDTH-1:0]                  data_o,
  output logic [SOURCE_COUNT-1:0]                grant_oh_o,
  output logic [IDX_WIDTH-1:0]                   grant_idx_o
);

  logic                    w_load_en;
  logic                    w_xfer;
  logic [SOURCE_COUNT-1:0] w_req;
  logic [SOURCE_COUNT-1:0] w_win_oh;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic [IDX_WIDTH-1:0]    w_win_idx;

  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [SOURCE_COUNT-1:0] r_grant_oh;
  logic [IDX_WIDTH-1:0]    r_grant_idx;

`ifdef RR_ARB_MUX_PRIO_EN
  logic [SOURCE_COUNT-1:0] w_hi_req;
  assign w_hi_req = valid_i & prio_i;
  assign w_req    = (|w_hi_req) ? w_hi_req : valid_i;
`else
  assign w_req = valid_i;
`endif

  rr_arbiter #(
    .SOURCE_COUNT(SOURCE_COUNT)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (w_req),
    .advance_i (w_xfer),
    .grant_oh_o(w_win_oh)
  );

  // Drain and refill in the same cycle keeps the stage bubble-free.
  assign w_load_en = ~r_valid | ready_i;
  assign ready_o   = w_win_oh & {SOURCE_COUNT{w_load_en}};
  assign w_xfer    = |ready_o;
  assign w_win_idx = IDX_WIDTH'(onehot_to_idx(RR_ARB_MUX_MAX_SOURCES'(w_win_oh), SOURCE_COUNT));

  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < SOURCE_COUNT; j++) begin
      w_sel_data = w_sel_data | (data_i[j] & {DATA_WIDTH{w_win_oh[j]}});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_grant_oh  <= '0;
      r_grant_idx <= '0;
    end else if (w_load_en) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_data      <= w_sel_data;
        r_grant_oh  <= w_win_oh;
        r_grant_idx <= w_win_idx;
      end
    end
  end

  assign valid_o     = r_valid;
  assign data_o      = r_data;
  assign grant_oh_o  = r_grant_oh;
  assign grant_idx_o = r_grant_idx;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (4 sources, 64-bit payload) with hand-computed expectations.
module tb_rr_arb_mux;

  logic             clk;
  logic             rst;
  logic [3:0]       valid_i;
  logic [3:0][63:0] data_i;
  logic [3:0]       ready_o;
  logic             valid_o;
  logic             ready_i;
  logic [63:0]      data_o;
  logic [3:0]       grant_oh_o;
  logic [1:0]       grant_idx_o;
`ifdef RR_ARB_MUX_PRIO_EN
  logic [3:0]       prio_i;
`endif

  int n_pass;
  int n_total;

  rr_arb_mux #(
    .SOURCE_COUNT(4),
    .DATA_WIDTH  (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
`ifdef RR_ARB_MUX_PRIO_EN
    .prio_i     (prio_i),
`endif
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .grant_oh_o (grant_oh_o),
    .grant_idx_o(grant_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    data_i[0] = 64'h1111_0000_0000_1111;
    data_i[1] = 64'h2222_0000_0000_2222;
    data_i[2] = 64'h3333_0000_0000_3333;
    data_i[3] = 64'h4444_0000_0000_4444;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 4'b0000; ready_i = 1'b1;
    step(); step();
    rst = 1'b0;
    n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_o); else n_pass++;
    n_total++; if (data_o !== 64'h0) $display("FAIL reset_data got %h want 0", data_o); else n_pass++;
    n_total++; if (grant_oh_o !== 4'b0000) $display("FAIL reset_grant_oh got %b want 0000", grant_oh_o); else n_pass++;
    n_total++; if (grant_idx_o !== 2'd0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx_o); else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0]  exp_oh;
    logic [63:0] exp_data;
    load_data();
    valid_i = 4'b1111; ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_oh   = 4'b0001 << (k % 4);
      exp_data = data_i[k % 4];
      #1;
      n_total++; if (ready_o !== exp_oh) $display("FAIL rot_ready[%0d] got %b want %b", k, ready_o, exp_oh); else n_pass++;
      step();
      n_total++; if (valid_o !== 1'b1) $display("FAIL rot_valid[%0d] got %0b want 1", k, valid_o); else n_pass++;
      n_total++; if (grant_idx_o !== 2'(k % 4)) $display("FAIL rot_idx[%0d] got %0d want %0d", k, grant_idx_o, k % 4); else n_pass++;
      n_total++; if (data_o !== exp_data) $display("FAIL rot_data[%0d] got %h want %h", k, data_o, exp_data); else n_pass++;
    end
  endtask

  task automatic test_single();
    valid_i = 4'b0100; ready_i = 1'b1;
    data_i[2] = 64'hDEAD_BEEF;
    #1;
    n_total++; if (ready_o !== 4'b0100) $display("FAIL single_ready got %b want 0100", ready_o); else n_pass++;
    step();
    n_total++; if (data_o !== 64'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", data_o); else n_pass++;
    n_total++; if (grant_oh_o !== 4'b0100) $display("FAIL single_oh got %b want 0100", grant_oh_o); else n_pass++;
    n_total++; if (grant_idx_o !== 2'd2) $display("FAIL single_idx got %0d want 2", grant_idx_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    load_data();
    valid_i = 4'b1111; ready_i = 1'b1;
    #1;
    n_total++; if (ready_o !== 4'b1000) $display("FAIL bp_first_ready got %b want 1000", ready_o); else n_pass++;
    step();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if (ready_o !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", k, ready_o); else n_pass++;
      step();
      n_total++; if (valid_o !== 1'b1) $display("FAIL bp_valid[%0d] got %0b want 1", k, valid_o); else n_pass++;
      n_total++; if (grant_idx_o !== 2'd3) $display("FAIL bp_idx[%0d] got %0d want 3", k, grant_idx_o); else n_pass++;
      n_total++; if (data_o !== 64'h4444_0000_0000_4444) $display("FAIL bp_data[%0d] got %h want 4444000000004444", k, data_o); else n_pass++;
    end
    ready_i = 1'b1;
    #1;
    n_total++; if (ready_o !== 4'b0001) $display("FAIL bp_resume_ready got %b want 0001", ready_o); else n_pass++;
    step();
    n_total++; if (grant_idx_o !== 2'd0) $display("FAIL bp_resume_idx got %0d want 0", grant_idx_o); else n_pass++;
  endtask

  task automatic test_idle_drain();
    valid_i = 4'b0000; ready_i = 1'b1;
    #1;
    n_total++; if (ready_o !== 4'b0000) $display("FAIL idle_ready got %b want 0000", ready_o); else n_pass++;
    step();
    n_total++; if (valid_o !== 1'b0) $display("FAIL idle_valid got %0b want 0", valid_o); else n_pass++;
    n_total++; if (grant_idx_o !== 2'd0) $display("FAIL idle_idx_hold got %0d want 0", grant_idx_o); else n_pass++;
  endtask

  task automatic test_skip_wrap();
    // Pointer sits at source 0: 1 wins next, then a lone source 0 wins by wrapping.
    valid_i = 4'b1010; ready_i = 1'b1;
    step();
    n_total++; if (grant_idx_o !== 2'd1) $display("FAIL skip_idx got %0d want 1", grant_idx_o); else n_pass++;
    valid_i = 4'b0001;
    step();
    n_total++; if (grant_oh_o !== 4'b0001) $display("FAIL wrap_oh got %b want 0001", grant_oh_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    valid_i = 4'b1111; ready_i = 1'b1;
    step();
    n_total++; if (grant_idx_o !== 2'd1) $display("FAIL mid_pre_idx got %0d want 1", grant_idx_o); else n_pass++;
    ready_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (valid_o !== 1'b0) $display("FAIL mid_valid got %0b want 0", valid_o); else n_pass++;
    ready_i = 1'b1;
    #1;
    n_total++; if (ready_o !== 4'b0001) $display("FAIL mid_ready got %b want 0001", ready_o); else n_pass++;
    step();
    n_total++; if (grant_idx_o !== 2'd0) $display("FAIL mid_idx got %0d want 0", grant_idx_o); else n_pass++;
  endtask

`ifdef RR_ARB_MUX_PRIO_EN
  task automatic test_prio();
    logic [1:0] exp_hi [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    rst = 1'b1; valid_i = 4'b0000; ready_i = 1'b1; prio_i = 4'b0000;
    step();
    rst = 1'b0;
    valid_i = 4'b1111; prio_i = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++; if (grant_idx_o !== exp_hi[k]) $display("FAIL prio_idx[%0d] got %0d want %0d", k, grant_idx_o, exp_hi[k]); else n_pass++;
    end
    prio_i = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      step();
      n_total++; if (grant_idx_o !== 2'(k)) $display("FAIL noprio_idx[%0d] got %0d want %0d", k, grant_idx_o, k); else n_pass++;
    end
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; valid_i = '0; ready_i = 1'b0; data_i = '0;
`ifdef RR_ARB_MUX_PRIO_EN
    prio_i = '0;
`endif
    test_reset();
    test_rotation();
    test_single();
    test_backpressure();
    test_idle_drain();
    test_skip_wrap();
    test_reset_mid();
`ifdef RR_ARB_MUX_PRIO_EN
    test_prio();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
